// File: rtl/aclk_pkg.sv
// Shared types and BCD limits for the alarm-clock controller.
// Holds the FSM state encoding and the entry validation helper.
package aclk_pkg;

  typedef enum logic [1:0] {
    SHOW_TIME  = 2'd0,
    KEY_ENTRY  = 2'd1,
    SHOW_ALARM = 2'd2
  } state_t;

  localparam logic [3:0] MAX_MS_HR       = 4'd2;
  localparam logic [3:0] MAX_LS_HR_AT_20 = 4'd3;
  localparam logic [3:0] MAX_MS_MIN      = 4'd5;
  localparam logic [3:0] DIGIT_MAX       = 4'd9;

  // A 24-hour HH:MM check; the ls digits are already bounded by DIGIT_MAX.
  function automatic logic entry_valid(input logic [3:0] ms_hr,
                                       input logic [3:0] ls_hr,
                                       input logic [3:0] ms_min);
    return (ms_hr <= MAX_MS_HR) &&
           !((ms_hr == MAX_MS_HR) && (ls_hr > MAX_LS_HR_AT_20)) &&
           (ms_min <= MAX_MS_MIN);
  endfunction

endpackage

// File: rtl/alarm_ring_ctrl.sv
// Alarm sounder: rings on the rising edge of cur==alarm, cleared by stop, disable or RING_SEC ticks.
// sound_alarm rises/falls one cycle after the triggering edge; no backpressure.
module alarm_ring_ctrl
  import aclk_pkg::*;
#(
  parameter int RING_SEC = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        one_second,
  input  logic        alarm_enable,
  input  logic        stop_alarm,
  input  logic [15:0] cur_time,
  input  logic [15:0] alarm_time,
  output logic        sound_alarm
);

  localparam int RW = $clog2(RING_SEC + 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);

  logic          match;
  logic          match_d;
  logic          ring_start;
  logic          ring_clear;
  logic [RW-1:0] ring_cnt;

  assign match      = (cur_time == alarm_time);
  assign ring_start = alarm_enable & match & ~match_d;
  assign ring_clear = stop_alarm | ~alarm_enable |
                      (sound_alarm & one_second & (ring_cnt == RING_LAST));

  // match_d resets high so an idle 00:00 == 00:00 is not seen as a new match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_d     <= 1'b1;
      sound_alarm <= 1'b0;
      ring_cnt    <= '0;
    end else begin
      match_d <= match;
      if (ring_clear) begin
        sound_alarm <= 1'b0;
        ring_cnt    <= '0;
      end else if (ring_start) begin
        sound_alarm <= 1'b1;
        ring_cnt    <= '0;
      end else if (sound_alarm && one_second) begin
        ring_cnt <= ring_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm-clock sequencer: keypad entry buffer, validation, load strobes, display select, ringing.
// Strobes and errors appear the cycle after the sampling edge; inputs are pulses, no backpressure.
module alarm_ctrl
  import aclk_pkg::*;
#(
  parameter int TIMEOUT_SEC = 10,
  parameter int SHOW_SEC    = 5,
  parameter int RING_SEC    = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key_digit,
  input  logic       key_valid,
  input  logic       alarm_button,
  input  logic       time_button,
  input  logic       alarm_enable,
  input  logic       stop_alarm,
  input  logic [3:0] cur_ms_hr,
  input  logic [3:0] cur_ls_hr,
  input  logic [3:0] cur_ms_min,
  input  logic [3:0] cur_ls_min,
  input  logic [3:0] alarm_ms_hr,
  input  logic [3:0] alarm_ls_hr,
  input  logic [3:0] alarm_ms_min,
  input  logic [3:0] alarm_ls_min,
  output logic [3:0] key_ms_hr,
  output logic [3:0] key_ls_hr,
  output logic [3:0] key_ms_min,
  output logic [3:0] key_ls_min,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_new_time,
  output logic       show_a,
  output logic       entry_error,
  output logic       sound_alarm
);

  localparam int IDLE_MAX = (TIMEOUT_SEC > SHOW_SEC) ? TIMEOUT_SEC : SHOW_SEC;
  localparam int IW       = $clog2(IDLE_MAX + 1);
  localparam logic [IW-1:0] TO_LAST   = IW'(TIMEOUT_SEC - 1);
  localparam logic [IW-1:0] SHOW_LAST = IW'(SHOW_SEC - 1);
  localparam logic [IW-1:0] IDLE_SAT  = IW'(IDLE_MAX);

  state_t        state, state_n;
  logic [15:0]   key_buf, key_buf_n;
  logic [IW-1:0] idle_cnt;
  logic          digit_ok;
  logic          idle_expire;
  logic          idle_clr;
  logic          load_a_n, load_c_n, err_n;

  assign digit_ok    = key_valid && (key_digit <= DIGIT_MAX);
  assign idle_expire = one_second &&
                       (idle_cnt >= ((state == SHOW_ALARM) ? SHOW_LAST : TO_LAST));

  // Priority in KEY_ENTRY: both buttons > one button > digit > timeout.
  always_comb begin
    state_n   = state;
    key_buf_n = key_buf;
    load_a_n  = 1'b0;
    load_c_n  = 1'b0;
    err_n     = 1'b0;
    idle_clr  = 1'b0;
    case (state)
      SHOW_TIME: begin
        if (alarm_button) begin
          state_n = SHOW_ALARM;
        end else if (digit_ok) begin
          state_n   = KEY_ENTRY;
          key_buf_n = {12'h000, key_digit};
        end
      end
      KEY_ENTRY: begin
        if (alarm_button && time_button) begin
          state_n = SHOW_TIME;
          err_n   = 1'b1;
        end else if (alarm_button || time_button) begin
          state_n = SHOW_TIME;
          if (entry_valid(key_buf[15:12], key_buf[11:8], key_buf[7:4])) begin
            load_a_n = alarm_button;
            load_c_n = time_button;
          end else begin
            err_n = 1'b1;
          end
        end else if (digit_ok) begin
          key_buf_n = {key_buf[11:0], key_digit};
          idle_clr  = 1'b1;
        end else if (idle_expire) begin
          state_n = SHOW_TIME;
        end
      end
      SHOW_ALARM: begin
        if (alarm_button || idle_expire) state_n = SHOW_TIME;
      end
      default: state_n = SHOW_TIME;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SHOW_TIME;
      key_buf     <= 16'h0000;
      idle_cnt    <= '0;
      load_new_a  <= 1'b0;
      load_new_c  <= 1'b0;
      entry_error <= 1'b0;
    end else begin
      state       <= state_n;
      key_buf     <= key_buf_n;
      load_new_a  <= load_a_n;
      load_new_c  <= load_c_n;
      entry_error <= err_n;
      if ((state_n != state) || idle_clr) begin
        idle_cnt <= '0;
      end else if (one_second && (idle_cnt != IDLE_SAT)) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  assign key_ms_hr     = key_buf[15:12];
  assign key_ls_hr     = key_buf[11:8];
  assign key_ms_min    = key_buf[7:4];
  assign key_ls_min    = key_buf[3:0];
  assign show_new_time = (state == KEY_ENTRY);
  assign show_a        = (state == SHOW_ALARM);

  alarm_ring_ctrl #(
    .RING_SEC(RING_SEC)
  ) u_ring (
    .clk         (clk),
    .reset       (reset),
    .one_second  (one_second),
    .alarm_enable(alarm_enable),
    .stop_alarm  (stop_alarm),
    .cur_time    ({cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min}),
    .alarm_time  ({alarm_ms_hr, alarm_ls_hr, alarm_ms_min, alarm_ls_min}),
    .sound_alarm (sound_alarm)
  );

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with hand-computed expectations.
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       one_second, key_valid, alarm_button, time_button, alarm_enable, stop_alarm;
  logic [3:0] key_digit;
  logic [3:0] cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min;
  logic [3:0] alarm_ms_hr, alarm_ls_hr, alarm_ms_min, alarm_ls_min;
  logic [3:0] key_ms_hr, key_ls_hr, key_ms_min, key_ls_min;
  logic       load_new_a, load_new_c, show_new_time, show_a, entry_error, sound_alarm;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alarm_ctrl #(.TIMEOUT_SEC(10), .SHOW_SEC(5), .RING_SEC(60)) dut (
    .clk(clk), .reset(reset), .one_second(one_second),
    .key_digit(key_digit), .key_valid(key_valid),
    .alarm_button(alarm_button), .time_button(time_button),
    .alarm_enable(alarm_enable), .stop_alarm(stop_alarm),
    .cur_ms_hr(cur_ms_hr), .cur_ls_hr(cur_ls_hr), .cur_ms_min(cur_ms_min), .cur_ls_min(cur_ls_min),
    .alarm_ms_hr(alarm_ms_hr), .alarm_ls_hr(alarm_ls_hr),
    .alarm_ms_min(alarm_ms_min), .alarm_ls_min(alarm_ls_min),
    .key_ms_hr(key_ms_hr), .key_ls_hr(key_ls_hr), .key_ms_min(key_ms_min), .key_ls_min(key_ls_min),
    .load_new_a(load_new_a), .load_new_c(load_new_c),
    .show_new_time(show_new_time), .show_a(show_a),
    .entry_error(entry_error), .sound_alarm(sound_alarm)
  );

  wire [15:0] key_buf = {key_ms_hr, key_ls_hr, key_ms_min, key_ls_min};
  // {load_new_a, load_new_c, entry_error}
  wire [2:0]  strobes = {load_new_a, load_new_c, entry_error};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_key(input logic [3:0] d);
    key_digit = d; key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  task automatic press_buttons(input logic a, input logic t);
    alarm_button = a; time_button = t;
    step();
    alarm_button = 1'b0; time_button = 1'b0;
  endtask

  task automatic tick();
    one_second = 1'b1;
    step();
    one_second = 1'b0;
    step();
  endtask

  task automatic set_cur(input logic [15:0] v);
    {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min} = v;
  endtask

  task automatic set_alarm(input logic [15:0] v);
    {alarm_ms_hr, alarm_ls_hr, alarm_ms_min, alarm_ls_min} = v;
  endtask

  initial begin
    reset = 1'b0; one_second = 0; key_valid = 0; key_digit = 0;
    alarm_button = 0; time_button = 0; alarm_enable = 1; stop_alarm = 0;
    set_cur(16'h0000); set_alarm(16'h0000);
    step(); step();
    check("rst_buf", key_buf, 16'h0000);
    check("rst_strobes", strobes, 3'b000);
    check("rst_show", {show_new_time, show_a}, 2'b00);
    check("rst_sound", sound_alarm, 1'b0);
    reset = 1'b1;
    step(); step(); step();
    check("post_rst_no_ring", sound_alarm, 1'b0);
    check("post_rst_show", {show_new_time, show_a}, 2'b00);

    // Digit > 9 ignored in SHOW_TIME
    press_key(4'd12);
    check("bad_digit_idle", {show_new_time, key_buf}, {1'b0, 16'h0000});

    // 0,7,3,0 + alarm_button -> 07:30 loaded into alarm
    press_key(4'd0);
    check("entry_start", {show_new_time, key_buf}, {1'b1, 16'h0000});
    press_key(4'd7);
    check("shift_7", key_buf, 16'h0007);
    press_key(4'd11);
    check("bad_digit_entry", key_buf, 16'h0007);
    press_key(4'd3);
    press_key(4'd0);
    check("buf_0730", key_buf, 16'h0730);
    press_buttons(1'b1, 1'b0);
    check("load_a_pulse", strobes, 3'b100);
    check("load_a_state", show_new_time, 1'b0);
    step();
    check("load_a_one_cycle", strobes, 3'b000);
    check("buf_hold", key_buf, 16'h0730);

    // 2,5,0,0 + time_button -> invalid hour
    press_key(4'd2); press_key(4'd5); press_key(4'd0); press_key(4'd0);
    check("buf_2500", key_buf, 16'h2500);
    press_buttons(1'b0, 1'b1);
    check("err_2500", strobes, 3'b001);
    step();
    check("err_one_cycle", strobes, 3'b000);

    // Five digits drop the oldest; 23:45 is valid boundary
    press_key(4'd1); press_key(4'd2); press_key(4'd3); press_key(4'd4); press_key(4'd5);
    check("buf_overflow", key_buf, 16'h2345);
    press_buttons(1'b0, 1'b1);
    check("load_c_2345", strobes, 3'b010);

    // 19:60 : ms_min 6 rejected
    press_key(4'd1); press_key(4'd9); press_key(4'd6); press_key(4'd0);
    press_buttons(1'b1, 1'b0);
    check("err_min_6", strobes, 3'b001);

    // Button beats a same-cycle digit
    press_key(4'd1); press_key(4'd2); press_key(4'd3); press_key(4'd0);
    key_digit = 4'd5; key_valid = 1'b1;
    press_buttons(1'b1, 1'b0);
    key_valid = 1'b0;
    check("btn_beats_key", {strobes, key_buf}, {3'b100, 16'h1230});

    // Both buttons -> error only
    press_key(4'd0); press_key(4'd8); press_key(4'd0); press_key(4'd0);
    press_buttons(1'b1, 1'b1);
    check("both_buttons", {strobes, show_new_time}, {3'b001, 1'b0});

    // Keys 1,2 then timeout on the 10th tick
    press_key(4'd1); press_key(4'd2);
    for (int i = 0; i < 9; i++) tick();
    check("timeout_9", {show_new_time, key_buf}, {1'b1, 16'h0012});
    one_second = 1'b1;
    step();
    one_second = 1'b0;
    check("timeout_10", {show_new_time, strobes}, {1'b0, 3'b000});
    step();
    check("timeout_no_strobe", strobes, 3'b000);

    // SHOW_ALARM: keys ignored, exits after 5 ticks
    press_buttons(1'b1, 1'b0);
    check("show_a_on", {show_a, show_new_time}, 2'b10);
    press_key(4'd3);
    check("show_a_key_ignored", {show_a, show_new_time}, 2'b10);
    for (int i = 0; i < 4; i++) tick();
    check("show_a_4ticks", show_a, 1'b1);
    tick();
    check("show_a_5ticks", show_a, 1'b0);
    press_buttons(1'b1, 1'b0);
    press_buttons(1'b1, 1'b0);
    check("show_a_second_btn", show_a, 1'b0);

    // Ringing: 07:29 -> 07:30
    set_alarm(16'h0730); set_cur(16'h0729);
    step();
    check("ring_pre", sound_alarm, 1'b0);
    set_cur(16'h0730);
    step();
    check("ring_start", sound_alarm, 1'b1);
    step();
    stop_alarm = 1'b1;
    step();
    stop_alarm = 1'b0;
    check("ring_stop", sound_alarm, 1'b0);
    step(); step(); step();
    check("ring_no_retrigger", sound_alarm, 1'b0);

    // Auto-clear on the 60th tick
    set_cur(16'h0731); step();
    set_cur(16'h0730); step();
    check("ring_restart", sound_alarm, 1'b1);
    for (int i = 0; i < 59; i++) tick();
    check("ring_59", sound_alarm, 1'b1);
    one_second = 1'b1;
    step();
    one_second = 1'b0;
    check("ring_60", sound_alarm, 1'b0);

    // Disable clears; clear beats start
    set_cur(16'h0731); step();
    set_cur(16'h0730); step();
    check("ring_again", sound_alarm, 1'b1);
    alarm_enable = 1'b0;
    step();
    check("ring_disable", sound_alarm, 1'b0);
    alarm_enable = 1'b1;
    set_cur(16'h0731); step();
    set_cur(16'h0730); stop_alarm = 1'b1;
    step();
    stop_alarm = 1'b0;
    check("clear_beats_start", sound_alarm, 1'b0);
    step();
    check("clear_beats_start_hold", sound_alarm, 1'b0);

    // Reset mid-entry
    press_key(4'd4); press_key(4'd5);
    check("mid_entry", key_buf, 16'h0045);
    reset = 1'b0;
    #2;
    check("rst_mid_entry", {show_new_time, key_buf, strobes}, {1'b0, 16'h0000, 3'b000});
    step();
    reset = 1'b1;
    step();
    check("after_rst_idle", {show_new_time, strobes}, {1'b0, 3'b000});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm-clock sequencing controller. Collects keypad digits into a 4-digit entry buffer and validates the entry. Issues one-cycle load pulses to the alarm register (`load_new_a`) or the current-time counter (`load_new_c`), and drives the display-select flags. Also detects the current time reaching the stored alarm time and drives the alarm sounder with stop and auto-timeout.

## Interface
Parameters:
- TIMEOUT_SEC, 10, `one_second` ticks with no key before an entry is abandoned
- SHOW_SEC, 5, `one_second` ticks the alarm time stays displayed
- RING_SEC, 60, `one_second` ticks before the sounder self-clears

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low: asserted at 0, released at 1
- one_second  in  1  one-cycle tick per second
- key_digit  in  4  keypad value, sampled only when key_valid=1
- key_valid  in  1  one-cycle pulse, debounced upstream
- alarm_button  in  1  one-cycle pulse
- time_button  in  1  one-cycle pulse
- alarm_enable  in  1  level; 0 disables and clears ringing
- stop_alarm  in  1  level or pulse; clears ringing
- cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min  in  4 each  current time, BCD
- alarm_ms_hr, alarm_ls_hr, alarm_ms_min, alarm_ls_min  in  4 each  stored alarm time, BCD
- key_ms_hr, key_ls_hr, key_ms_min, key_ls_min  out  4 each  entry buffer; feeds new_alarm_* and the new-time inputs
- load_new_a  out  1  one-cycle load strobe to the alarm register
- load_new_c  out  1  one-cycle load strobe to the time counter
- show_new_time  out  1  display the entry buffer
- show_a  out  1  display the alarm time
- entry_error  out  1  one-cycle pulse on a rejected entry
- sound_alarm  out  1  sounder drive

## Operation
- FSM states are SHOW_TIME, KEY_ENTRY and SHOW_ALARM.
- Reset state is SHOW_TIME. All outputs are 0 at reset, and the entry buffer is 0000.

SHOW_TIME:
- key_valid with a digit of 9 or less: clear the buffer, shift the digit in, go to KEY_ENTRY.
- alarm_button: go to SHOW_ALARM.
- Digits greater than 9 are ignored in every state.

KEY_ENTRY (show_new_time=1):
- Each valid digit shifts left: ms_hr←ls_hr, ls_hr←ms_min, ms_min←ls_min, ls_min←digit. Keying 0,7,3,0 gives 07:30.
- After more than 4 digits, the oldest digit is dropped.
- alarm_button: validate the buffer (ms_hr ≤2; if ms_hr=2 then ls_hr ≤3; ms_min ≤5). If valid, pulse load_new_a; otherwise pulse entry_error. Either way go to SHOW_TIME.
- time_button: same validation, but pulses load_new_c.
- Timeout: go to SHOW_TIME with no load and no error.

SHOW_ALARM (show_a=1):
- Exit to SHOW_TIME after SHOW_SEC ticks, or on a second alarm_button.
- key_valid is ignored.

Idle counter:
- Cleared on every state change and on every accepted key.
- Increments on one_second and saturates at the limit.

Same-cycle priority in KEY_ENTRY:
- alarm_button and time_button together: entry_error, go to SHOW_TIME.
- A button beats key_valid; the digit is dropped.
- A button beats timeout.

Alarm match and ringing:
- match is equality of all four cur_* and alarm_* digits. match_d is match registered, and resets to 1 so 00:00==00:00 does not ring after reset.
- Ring start: alarm_enable & match & ~match_d sets sound_alarm.
- Ring clear: stop_alarm, ~alarm_enable, or RING_SEC ticks.
- Clear has priority over start in the same cycle.
- Ringing is independent of the FSM state.

## Timing
- The FSM, buffer, load strobes and entry_error are all registered.
- A button sampled at edge N produces a strobe high for exactly cycle N+1.
- The buffer is stable during the strobe and holds until the next entry begins.
- A digit sampled at edge N appears on key_* in cycle N+1.
- Timeout takes effect at the edge where the TIMEOUT_SEC-th tick is sampled.
- sound_alarm rises 1 cycle after the match edge and falls 1 cycle after a clear condition.
- Reset mid-entry drops the buffer to 0000, with no strobe and no error.

## Structure
- Shared package `aclk_pkg` holds:
  - the state enum;
  - BCD limit constants MAX_MS_HR=2, MAX_LS_HR_AT_20=3 and MAX_MS_MIN=5;
  - DIGIT_MAX=9.
- Sub-module `alarm_ring_ctrl` holds match, match_d, the ring counter and sound_alarm.
- `alarm_ctrl` holds the FSM, the buffer, validation and the idle counter.

## Test plan
- Reset released with alarm_enable=1 and cur=alarm=00:00 → sound_alarm stays 0; all outputs 0.
- Keys 0,7,3,0 then alarm_button → key_*=07:30, load_new_a high exactly 1 cycle, state SHOW_TIME.
- Keys 2,5,0,0 then time_button → entry_error pulse, no load_new_c.
- Keys 1,2 then 10 one_second ticks → SHOW_TIME, show_new_time=0, no strobes.
- alarm=07:30 and cur steps 07:29→07:30 → sound_alarm=1 next cycle; stop_alarm → 0; no retrigger while cur stays 07:30.
- alarm_button and time_button in the same cycle during entry → entry_error only.
